// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, ALU-op encoding and controller states shared by mips_mc.
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_IMMEX, S_IMMWB, S_BRANCH, S_JUMP, S_TRAP
    } state_e;

    function automatic logic funct_ok(input logic [5:0] fn);
        return fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR || fn == FN_SLT;
    endfunction

    function automatic alu_op_e funct_alu(input logic [5:0] fn);
        return fn == FN_SUB ? ALU_SUB : fn == FN_AND ? ALU_AND : fn == FN_OR ? ALU_OR :
               fn == FN_SLT ? ALU_SLT : ALU_ADD;
    endfunction

    function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        return op == ALU_SUB ? a - b : op == ALU_AND ? a & b : op == ALU_OR ? a | b :
               op == ALU_SLT ? {31'd0, $signed(a) < $signed(b)} : a + b;
    endfunction
endpackage

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle controller FSM and instruction decode.
// Emits datapath strobes; bus request outputs are forced low while reset is held.
module mips_mc_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output alu_op_e    alu_op,
    output logic       alu_imm,
    output logic       imm_logic,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_data,
    output logic       ir_we,
    output logic       ab_we,
    output logic       alu_we,
    output logic       mdr_we,
    output logic       pc_inc,
    output logic       pc_br,
    output logic       pc_jmp,
    output logic       reg_we,
    output logic       wb_rd,
    output logic       wb_mem,
    output logic       retired,
    output logic       trap
);
    state_e state_q, state_d;
    logic   req, we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        alu_op    = ALU_ADD;
        alu_imm   = 1'b0;
        imm_logic = 1'b0;
        req       = 1'b0;
        we        = 1'b0;
        mem_data  = 1'b0;
        ir_we     = 1'b0;
        ab_we     = 1'b0;
        alu_we    = 1'b0;
        mdr_we    = 1'b0;
        pc_inc    = 1'b0;
        pc_br     = 1'b0;
        pc_jmp    = 1'b0;
        reg_we    = 1'b0;
        wb_rd     = 1'b0;
        wb_mem    = 1'b0;
        retired   = 1'b0;
        trap      = 1'b0;
        case (state_q)
            S_FETCH: begin
                req     = 1'b1;
                ir_we   = mem_ready;
                pc_inc  = mem_ready;
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ab_we = 1'b1;
                case (opcode)
                    OP_LW, OP_SW:              state_d = S_MEMADR;
                    OP_RTYPE:                  state_d = funct_ok(funct) ? S_EXEC : S_TRAP;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IMMEX;
                    OP_BEQ:                    state_d = S_BRANCH;
                    OP_J:                      state_d = S_JUMP;
                    default:                   state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_imm = 1'b1;
                alu_we  = 1'b1;
                state_d = opcode == OP_LW ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                req      = 1'b1;
                mem_data = 1'b1;
                mdr_we   = mem_ready;
                state_d  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_we  = 1'b1;
                wb_mem  = 1'b1;
                retired = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                req      = 1'b1;
                we       = 1'b1;
                mem_data = 1'b1;
                retired  = mem_ready;
                state_d  = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_op  = funct_alu(funct);
                alu_we  = 1'b1;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we  = 1'b1;
                wb_rd   = 1'b1;
                retired = 1'b1;
                state_d = S_FETCH;
            end
            S_IMMEX: begin
                alu_imm   = 1'b1;
                imm_logic = opcode == OP_ANDI || opcode == OP_ORI;
                alu_op    = opcode == OP_ANDI ? ALU_AND : opcode == OP_ORI ? ALU_OR : ALU_ADD;
                alu_we    = 1'b1;
                state_d   = S_IMMWB;
            end
            S_IMMWB: begin
                reg_we  = 1'b1;
                retired = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                pc_br   = 1'b1;
                retired = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_jmp  = 1'b1;
                retired = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP:  trap = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    assign mem_req = req & reset;
    assign mem_we  = we & reset;
endmodule

// File: rtl/mips_mc.sv
// mips_mc: multicycle MIPS subset core on a single unified memory port.
// Register file, ALU and PC live here; sequencing comes from mips_mc_ctrl.
module mips_mc
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic        ZEXT_LOGIC = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        retired,
    output logic        trap
);
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
    logic [31:0] regs_q [32];
    logic [31:0] sext, imm, alu_y, wd;
    logic [4:0]  wa;
    alu_op_e     alu_op;
    logic        alu_imm, imm_logic, mem_data, ir_we, ab_we, alu_we, mdr_we;
    logic        pc_inc, pc_br, pc_jmp, reg_we, wb_rd, wb_mem;

    mips_mc_ctrl u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .opcode    (ir_q[31:26]),
        .funct     (ir_q[5:0]),
        .mem_ready (mem_ready),
        .alu_op    (alu_op),
        .alu_imm   (alu_imm),
        .imm_logic (imm_logic),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_data  (mem_data),
        .ir_we     (ir_we),
        .ab_we     (ab_we),
        .alu_we    (alu_we),
        .mdr_we    (mdr_we),
        .pc_inc    (pc_inc),
        .pc_br     (pc_br),
        .pc_jmp    (pc_jmp),
        .reg_we    (reg_we),
        .wb_rd     (wb_rd),
        .wb_mem    (wb_mem),
        .retired   (retired),
        .trap      (trap)
    );

    always_comb begin
        sext  = {{16{ir_q[15]}}, ir_q[15:0]};
        imm   = (ZEXT_LOGIC && imm_logic) ? {16'd0, ir_q[15:0]} : sext;
        alu_y = alu(alu_op, a_q, alu_imm ? imm : b_q);
        ir_d  = ir_we ? mem_rdata : ir_q;
        a_d   = ab_we ? regs_q[ir_q[25:21]] : a_q;
        b_d   = ab_we ? regs_q[ir_q[20:16]] : b_q;
        alu_d = alu_we ? alu_y : alu_q;
        mdr_d = mdr_we ? mem_rdata : mdr_q;
        // pc already points past the branch/jump when BRANCH/JUMP run
        pc_d  = pc_inc ? pc_q + 32'd4 :
                (pc_br && a_q == b_q) ? pc_q + {sext[29:0], 2'b00} :
                pc_jmp ? {pc_q[31:28], ir_q[25:0], 2'b00} : pc_q;
        wa    = wb_rd ? ir_q[15:11] : ir_q[20:16];
        wd    = wb_mem ? mdr_q : alu_q;
    end

    assign mem_addr  = mem_data ? alu_q : pc_q;
    assign mem_wdata = b_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_PC;
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            alu_q <= '0;
            mdr_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            a_q   <= a_d;
            b_q   <= b_d;
            alu_q <= alu_d;
            mdr_q <= mdr_d;
        end
    end

    // r0 is never written, so it reads back as its reset value of zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (reg_we && wa != 5'd0) begin
            regs_q[wa] <= wd;
        end
    end
endmodule

// File: tb/tb_mips_mc.sv
// tb_mips_mc: directed programs against a wait-state memory model with hand-computed results.
module tb_mips_mc;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req, mem_we, mem_ready, retired, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [256];
    int          wait_n = 0;
    int          wcnt = 0;
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc, wr_n, stab_err, req_cnt;
    int          ret_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] wr_addr, wr_data, p_addr, p_wdata;
    logic        p_req, p_rdy, p_we;

    always #5 clk = ~clk;

    mips_mc dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .retired   (retired),
        .trap      (trap)
    );

    assign mem_ready = mem_req && (wcnt == wait_n);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;

    always @(negedge clk) begin
        if (!reset) begin
            cyc = 0;
            wr_n = 0;
            stab_err = 0;
            req_cnt = 0;
            p_req = 1'b0;
            ret_q.delete();
            rd_q.delete();
        end else begin
            cyc++;
            if (retired) ret_q.push_back(cyc);
            if (mem_req) req_cnt++;
            if (mem_req && p_req && !p_rdy && (mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wdata))
                stab_err++;
            if (mem_req && mem_ready && !mem_we) rd_q.push_back(mem_addr);
            if (mem_req && mem_ready && mem_we) begin
                wr_n++;
                wr_addr = mem_addr;
                wr_data = mem_wdata;
                mem[mem_addr[9:2]] = mem_wdata;
            end
            p_req = mem_req;
            p_rdy = mem_ready;
            p_we = mem_we;
            p_addr = mem_addr;
            p_wdata = mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] t);
        return {6'h02, t};
    endfunction

    function automatic logic [31:0] ret_at(input int i);
        return i < ret_q.size() ? ret_q[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] rd_at(input int i);
        return i < rd_q.size() ? rd_q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    // hold reset for a few cycles, release just after a rising edge so cycle 1 is FETCH
    task automatic start();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit found;
        // reset state
        clear_mem();
        #2;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_ret", {31'd0, retired}, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_pc", dut.pc_q, 32'd0);

        // zero-wait add sequence
        mem[0] = enc_i(6'h08, 0, 1, 16'd5);
        mem[1] = enc_i(6'h08, 0, 2, 16'd7);
        mem[2] = enc_r(6'h20, 3, 1, 2);
        mem[3] = enc_j(26'd3);
        start();
        run(14);
        chk("add_ret0", ret_at(0), 32'd4);
        chk("add_ret1", ret_at(1), 32'd8);
        chk("add_ret2", ret_at(2), 32'd12);
        chk("add_r1", dut.regs_q[1], 32'd5);
        chk("add_r3", dut.regs_q[3], 32'd12);
        reset = 1'b0;
        #1;
        chk("arst_r3", dut.regs_q[3], 32'd0);
        chk("arst_pc", dut.pc_q, 32'd0);
        chk("arst_req", {31'd0, mem_req}, 32'd0);

        // lw with three wait cycles per transaction
        clear_mem();
        wait_n = 3;
        mem[0] = enc_i(6'h23, 0, 4, 16'd8);
        mem[1] = enc_j(26'd1);
        mem[2] = 32'hDEAD_BEEF;
        start();
        run(12);
        chk("lw_ret", ret_at(0), 32'd11);
        chk("lw_r4", dut.regs_q[4], 32'hDEAD_BEEF);
        chk("lw_addr", rd_at(1), 32'd8);
        chk("lw_stable", stab_err, 32'd0);

        // beq taken at 0x10
        clear_mem();
        wait_n = 0;
        mem[0] = enc_i(6'h08, 0, 1, 16'd5);
        mem[1] = enc_i(6'h08, 0, 2, 16'd7);
        mem[2] = enc_j(26'd4);
        mem[4] = enc_i(6'h04, 1, 1, 16'hFFFF);
        start();
        run(20);
        chk("beqt_f3", rd_at(3), 32'h10);
        chk("beqt_f4", rd_at(4), 32'h10);
        chk("beqt_f5", rd_at(5), 32'h10);
        chk("j_ret", ret_at(2), 32'd11);
        chk("beq_ret", ret_at(3), 32'd14);

        // beq not taken at 0x10
        mem[4] = enc_i(6'h04, 1, 2, 16'd3);
        mem[5] = enc_i(6'h04, 0, 0, 16'hFFFF);
        start();
        run(20);
        chk("beqn_f4", rd_at(4), 32'h14);
        chk("beqn_f5", rd_at(5), 32'h14);

        // store and r0 writes
        clear_mem();
        mem[0] = enc_i(6'h08, 0, 3, 16'd12);
        mem[1] = enc_i(6'h2B, 0, 3, 16'd4);
        mem[2] = enc_i(6'h08, 0, 0, 16'd9);
        mem[3] = enc_i(6'h08, 0, 6, 16'd1);
        mem[4] = enc_j(26'd4);
        start();
        run(24);
        chk("sw_count", wr_n, 32'd1);
        chk("sw_addr", wr_addr, 32'd4);
        chk("sw_data", wr_data, 32'd12);
        chk("sw_mem", mem[1], 32'd12);
        chk("sw_ret", ret_at(1), 32'd8);
        chk("r0_val", dut.regs_q[0], 32'd0);
        chk("r0_read", dut.regs_q[6], 32'd1);

        // ALU operations, signed slt, zero-extended logic immediates, wrap
        clear_mem();
        mem[0]  = enc_i(6'h08, 0, 1, 16'hFFFD);
        mem[1]  = enc_i(6'h08, 0, 2, 16'd2);
        mem[2]  = enc_r(6'h2A, 3, 1, 2);
        mem[3]  = enc_r(6'h22, 4, 2, 1);
        mem[4]  = enc_r(6'h25, 5, 1, 2);
        mem[5]  = enc_r(6'h24, 6, 1, 2);
        mem[6]  = enc_i(6'h0C, 1, 7, 16'hFFF0);
        mem[7]  = enc_i(6'h0D, 0, 8, 16'h8000);
        mem[8]  = enc_r(6'h2A, 9, 2, 1);
        mem[9]  = enc_i(6'h08, 1, 10, 16'd5);
        mem[10] = enc_j(26'd10);
        start();
        run(44);
        chk("alu_r1", dut.regs_q[1], 32'hFFFF_FFFD);
        chk("slt_neg", dut.regs_q[3], 32'd1);
        chk("sub", dut.regs_q[4], 32'd5);
        chk("or", dut.regs_q[5], 32'hFFFF_FFFF);
        chk("and", dut.regs_q[6], 32'd0);
        chk("andi", dut.regs_q[7], 32'h0000_FFF0);
        chk("ori", dut.regs_q[8], 32'h0000_8000);
        chk("slt_pos", dut.regs_q[9], 32'd0);
        chk("addi_wrap", dut.regs_q[10], 32'd2);

        // illegal opcode traps until reset
        clear_mem();
        mem[0] = enc_i(6'h08, 0, 1, 16'd1);
        mem[1] = 32'hFC00_0000;
        start();
        run(8);
        chk("trap_set", {31'd0, trap}, 32'd1);
        req_cnt = 0;
        run(20);
        chk("trap_noreq", req_cnt, 32'd0);
        chk("trap_ret", ret_q.size(), 32'd1);
        chk("trap_hold", {31'd0, trap}, 32'd1);
        reset = 1'b0;
        #1;
        chk("trap_clr", {31'd0, trap}, 32'd0);
        start();
        @(negedge clk);
        chk("trap_refetch_req", {31'd0, mem_req}, 32'd1);
        chk("trap_refetch_addr", mem_addr, 32'd0);

        // reset during the MEMRD wait
        clear_mem();
        wait_n = 3;
        mem[0] = enc_i(6'h23, 0, 4, 16'd8);
        mem[1] = enc_j(26'd1);
        mem[2] = 32'hDEAD_BEEF;
        start();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = mem_req && !mem_we && mem_addr == 32'd8;
        end
        chk("mr_reach", {31'd0, found}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mr_req_drop", {31'd0, mem_req}, 32'd0);
        chk("mr_r4", dut.regs_q[4], 32'd0);
        start();
        @(negedge clk);
        chk("mr_refetch", mem_addr, 32'd0);
        chk("mr_refetch_we", {31'd0, mem_we}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
